// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM->WB register with valid/ready handshake, one-entry skid, flush and stall counter
module mem_wb_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Flush,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [DATA_W-1:0]      PCAddResult,
  input  logic [DATA_W-1:0]      MemReadData,
  input  logic [DATA_W-1:0]      ALUResult,
  input  logic [DATA_W-1:0]      BranchPCMemory,
  input  logic [RD_W-1:0]        RegRd,
  input  logic                   RegWrite,
  input  logic                   MemToReg,
  input  logic                   Jal,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [DATA_W-1:0]      PCAddResultOut,
  output logic [DATA_W-1:0]      MemReadDataOut,
  output logic [DATA_W-1:0]      ALUResultOut,
  output logic [DATA_W-1:0]      BranchPCWrite,
  output logic [RD_W-1:0]        RegRdOut,
  output logic                   RegWriteOut,
  output logic                   MemToRegOut,
  output logic                   JalOut,
  output logic [DATA_W-1:0]      WBData,
  output logic [STALL_CNT_W-1:0] StallCount
);
  localparam int P = 4*DATA_W + RD_W + 3;
  logic [P-1:0] main_q, skid_q, in_d;
  logic main_valid, skid_valid, in_fire, out_fire;
  assign in_d     = {PCAddResult, MemReadData, ALUResult, BranchPCMemory, RegRd, RegWrite, MemToReg, Jal};
  assign InReady  = !skid_valid;
  assign OutValid = main_valid;
  assign in_fire  = InValid & InReady;
  assign out_fire = main_valid & OutReady;
  assign {PCAddResultOut, MemReadDataOut, ALUResultOut, BranchPCWrite, RegRdOut} = main_q[P-1:3];
  assign RegWriteOut = main_valid & main_q[2];
  assign MemToRegOut = main_valid & main_q[1];
  assign JalOut      = main_valid & main_q[0];
  assign WBData = JalOut ? PCAddResultOut : MemToRegOut ? MemReadDataOut : ALUResultOut;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      StallCount <= '0;
    end else begin
      if (main_valid && !OutReady && !(&StallCount))
        StallCount <= StallCount + 1'b1;
      if (Flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || out_fire) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= in_fire;
          if (in_fire) skid_q <= in_d;
        end else begin
          main_valid <= in_fire;
          if (in_fire) main_q <= in_d;
        end
      end else if (in_fire) begin
        skid_q     <= in_d;
        skid_valid <= 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

Parametrised MEM→WB pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It sits between the data-memory stage and write-back. It carries the PC+4, memory read data, ALU result, branch PC, destination register and write-back controls. It replaces the free-running MEM/WB latch so that write-back back-pressure and pipeline flushes no longer drop or duplicate instructions.

## Interface
- DATA_W, 32, width of PC/data/ALU/branch-PC fields
- RD_W, 5, destination-register index width
- STALL_CNT_W, 16, width of stall counter

- Clk  input  1  clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- Flush  input  1  synchronous; discards all held and incoming entries
- InValid  input  1  upstream entry valid
- InReady  output  1  block can accept an entry
- PCAddResult, MemReadData, ALUResult, BranchPCMemory  input  DATA_W  payload fields
- RegRd  input  RD_W  destination register
- RegWrite, MemToReg, Jal  input  1  control fields
- OutValid  output  1  output entry valid
- OutReady  input  1  write-back consumes entry
- PCAddResultOut, MemReadDataOut, ALUResultOut, BranchPCWrite  output  DATA_W  registered payload
- RegRdOut  output  RD_W  registered destination
- RegWriteOut, MemToRegOut, JalOut  output  1  registered controls, gated by OutValid
- WBData  output  DATA_W  JalOut ? PCAddResultOut : MemToRegOut ? MemReadDataOut : ALUResultOut
- StallCount  output  STALL_CNT_W  cycles with OutValid=1, OutReady=0

## Operation
- Storage: main register (drives outputs) plus skid register, each with its own valid bit.
- InReady = !skid_valid. It is a registered value and has no combinational path from OutReady.
- Handshakes: in_fire = InValid & InReady; out_fire = OutValid & OutReady. OutValid = main_valid.
- Per edge, when Flush=0:
  - Main empty or out_fire, skid valid: main ← skid; skid ← input if in_fire, else skid empties.
  - Main empty or out_fire, skid empty: main ← input if in_fire, else main_valid ← 0.
  - Main held (valid and not out_fire), in_fire: skid ← input.
  - Main held, no in_fire: no change.
- Order is preserved strictly: an entry in skid always leaves before any later input.
- Flush=1 has priority over everything:
  - main_valid and skid_valid ← 0.
  - Any input presented that cycle is discarded, even if in_fire.
  - An out_fire in that cycle still counts as consumed.
  - Payload registers may retain stale data.
- Gating: RegWriteOut, MemToRegOut and JalOut are forced 0 while OutValid=0, so a bubble never writes the register file. Data outputs are undefined-but-stable while invalid.
- WBData is combinational from registered outputs only.
- StallCount:
  - Increments on every edge with OutValid & !OutReady.
  - Saturates at 2^STALL_CNT_W−1.
  - Unaffected by Flush.

## Timing
- Reset (async assert): all outputs 0, main_valid=skid_valid=0, InReady=1, StallCount=0. Reset deasserts synchronously to Clk externally.
- Latency: an entry accepted at edge N appears on outputs after edge N, with OutValid=1, when main was empty or fired.
- Throughput: one entry per cycle while OutReady=1.
- Backpressure: after OutReady drops, one more entry is accepted into skid. InReady falls the following cycle.
- Recovery: InReady returns to 1 the cycle after skid drains.
- Reset mid-operation: all held entries are lost immediately; no partial outputs.
- Simultaneous in_fire and out_fire with skid empty: pass-through, skid stays empty.

## Test plan
- Reset then stream: OutReady=1, inject 4 entries ALUResult=0x10..0x13 on consecutive cycles → OutValid 1 cycle later, values in order, InReady stays 1, StallCount=0.
- Backpressure:
  - Main holds 0xA; drop OutReady; present 0xB then 0xC → 0xB accepted into skid and InReady=0 next cycle; 0xC held upstream.
  - Raise OutReady → outputs 0xA, 0xB, 0xC on successive cycles.
  - StallCount equals stall cycles.
- Flush: main and skid full, assert Flush with InValid=1 (0xD) → next cycle OutValid=0, RegWriteOut=0, InReady=1; 0xD never appears.
- WBData mux: (Jal,MemToReg)=(1,x), (0,1), (0,0) with PC+4=0x104, Mem=0xBEEF, ALU=0x55 → WBData 0x104, 0xBEEF, 0x55.
- Saturation: STALL_CNT_W=4, hold OutValid=1, OutReady=0 for 20 cycles → StallCount=15.
- Async reset mid-stall: pulse Reset between edges → outputs, StallCount 0 immediately, InReady=1.
